// File: rtl/stage_update_pkg.sv
// Shared encodings for the lookup-stage update writer: command ops,
// response status codes and the writer FSM state type.
package stage_update_pkg;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam logic [1:0] ST_OK          = 2'b00;
    localparam logic [1:0] ST_VERIFY_FAIL = 2'b01;
    localparam logic [1:0] ST_WRONG_STAGE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_VISSUE,
        S_VCAPTURE,
        S_RESP
    } state_t;

endpackage

// File: rtl/stage_update_writer.sv
// Control-plane writer for one lookup-stage memory, driving port B.
// Define UPDATE_VERIFY_EN to read back every write and report VERIFY_FAIL on mismatch.
module stage_update_writer
    import stage_update_pkg::*;
#(
    parameter int STAGE_ID   = 0,
    parameter int DATA       = 72,
    parameter int ADDR       = 10,
    parameter int STAGE_BITS = 5,
    parameter int CNT_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [STAGE_BITS-1:0] cmd_stage,
    input  logic [ADDR-1:0]       cmd_addr,
    input  logic [DATA-1:0]       cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA-1:0]       rsp_data,
    output logic [1:0]            rsp_status,
    output logic                  b_wr,
    output logic [ADDR-1:0]       b_addr,
    output logic [DATA-1:0]       b_din,
    input  logic [DATA-1:0]       b_dout,
    output logic [CNT_BITS-1:0]   wr_count
);

    state_t                state, state_d;
    logic                  op_q, op_d;
    logic                  cmd_ready_d;
    logic                  rsp_valid_d;
    logic [DATA-1:0]       rsp_data_d;
    logic [1:0]            rsp_status_d;
    logic                  b_wr_d;
    logic [ADDR-1:0]       b_addr_d;
    logic [DATA-1:0]       b_din_d;
    logic [CNT_BITS-1:0]   wr_count_d;
    logic                  accept;
    logic                  stage_hit;

    assign accept    = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign stage_hit = (cmd_stage == STAGE_BITS'(STAGE_ID));

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= OP_READ;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= ST_OK;
            b_wr       <= 1'b0;
            b_addr     <= '0;
            b_din      <= '0;
            wr_count   <= '0;
        end else begin
            state      <= state_d;
            op_q       <= op_d;
            cmd_ready  <= cmd_ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_data   <= rsp_data_d;
            rsp_status <= rsp_status_d;
            b_wr       <= b_wr_d;
            b_addr     <= b_addr_d;
            b_din      <= b_din_d;
            wr_count   <= wr_count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (accept) state_d = stage_hit ? S_ISSUE : S_RESP;
            end
            S_ISSUE: state_d = S_CAPTURE;
            S_CAPTURE: begin
`ifdef UPDATE_VERIFY_EN
                state_d = (op_q == OP_WRITE) ? S_VISSUE : S_RESP;
`else
                state_d = S_RESP;
`endif
            end
`ifdef UPDATE_VERIFY_EN
            S_VISSUE:   state_d = S_VCAPTURE;
            S_VCAPTURE: state_d = S_RESP;
`endif
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; b_addr/b_din double as the
    // latched command address/data, so they simply hold outside IDLE.
    always_comb begin
        op_d         = op_q;
        rsp_data_d   = rsp_data;
        rsp_status_d = rsp_status;
        b_wr_d       = 1'b0;
        b_addr_d     = b_addr;
        b_din_d      = b_din;
        wr_count_d   = wr_count;
        cmd_ready_d  = (state_d == S_IDLE);
        rsp_valid_d  = (state_d == S_RESP);
        case (state)
            S_IDLE: begin
                if (accept && stage_hit) begin
                    op_d     = cmd_op;
                    b_wr_d   = cmd_op;
                    b_addr_d = cmd_addr;
                    b_din_d  = cmd_data;
                end else if (accept) begin
                    rsp_data_d   = '0;
                    rsp_status_d = ST_WRONG_STAGE;
                end
            end
            S_CAPTURE: begin
                // Read-first memory: this is the pre-access word for reads and writes
                rsp_data_d   = b_dout;
                rsp_status_d = ST_OK;
                if (op_q == OP_WRITE) wr_count_d = wr_count + CNT_BITS'(1);
            end
`ifdef UPDATE_VERIFY_EN
            S_VISSUE: begin
                b_addr_d = b_addr;
            end
            S_VCAPTURE: begin
                rsp_status_d = (b_dout == b_din) ? ST_OK : ST_VERIFY_FAIL;
            end
`endif
            default: begin
                b_wr_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_stage_update_writer.sv
// Directed bench for stage_update_writer with a read-first port-B memory model.
module tb_stage_update_writer;
    import stage_update_pkg::*;

    localparam int CNT = 4;   // narrow counter keeps the wrap reachable in a few writes
`ifdef UPDATE_VERIFY_EN
    localparam int WR_LAT = 5;
    localparam logic [1:0] CORRUPT_ST = ST_VERIFY_FAIL;
`else
    localparam int WR_LAT = 3;
    localparam logic [1:0] CORRUPT_ST = ST_OK;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_op = 1'b0;
    logic [4:0]     cmd_stage = '0;
    logic [9:0]     cmd_addr = '0;
    logic [71:0]    cmd_data = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [71:0]    rsp_data;
    logic [1:0]     rsp_status;
    logic           b_wr;
    logic [9:0]     b_addr;
    logic [71:0]    b_din;
    logic [71:0]    b_dout;
    logic [CNT-1:0] wr_count;

    logic [71:0] mem [0:1023];
    logic [71:0] mem_q;
    logic [71:0] corrupt = '0;
    int          wr_pulses = 0;
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (b_wr) mem[b_addr] <= b_din;
        mem_q <= mem[b_addr];
        if (b_wr) wr_pulses <= wr_pulses + 1;
    end
    assign b_dout = mem_q ^ corrupt;

    stage_update_writer #(.STAGE_ID(0), .DATA(72), .ADDR(10), .STAGE_BITS(5), .CNT_BITS(CNT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_stage(cmd_stage), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_status(rsp_status),
        .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout),
        .wr_count(wr_count)
    );

    // Present one command; returns #1 after the accepting edge.
    task automatic send_cmd(input logic op, input logic [4:0] stg,
                            input logic [9:0] a, input logic [71:0] d);
        logic rdy;
        int   n;
        logic done;
        cmd_op = op; cmd_stage = stg; cmd_addr = a; cmd_data = d;
        cmd_valid = 1'b1;
        n = 0; done = 1'b0;
        while (!done) begin
            rdy = cmd_ready;
            @(posedge clk); #1;
            if (rdy) done = 1'b1;
            else begin
                n++;
                if (n > 50) begin
                    checks++; errors++;
                    $display("FAIL cmd_accept: not accepted after %0d cycles, required acceptance", n);
                    done = 1'b1;
                end
            end
        end
        cmd_valid = 1'b0;
    endtask

    // Cycles from the accepting edge until rsp_valid is sampled high (bounded).
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %0b want 0", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); end
        checks++; if (rsp_data !== 72'h0 || rsp_status !== 2'b00) begin errors++; $display("FAIL rst_rsp: data %0h status %0b want 0/00", rsp_data, rsp_status); end
        checks++; if (b_wr !== 1'b0 || b_addr !== 10'h0 || b_din !== 72'h0) begin errors++; $display("FAIL rst_portb: wr %0b addr %0h din %0h want 0", b_wr, b_addr, b_din); end
        checks++; if (wr_count !== '0) begin errors++; $display("FAIL rst_wr_count: got %0h want 0", wr_count); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b want 1", cmd_ready); end
    endtask

    task automatic test_write_read();
        int lat;
        wr_pulses = 0;
        send_cmd(OP_WRITE, 5'd0, 10'd5, 72'h123);
        wait_rsp(lat);
        exp_cnt++;
        checks++; if (lat !== WR_LAT) begin errors++; $display("FAIL write_latency: got %0d want %0d", lat, WR_LAT); end
        checks++; if (rsp_data !== 72'h0AB) begin errors++; $display("FAIL write_old_data: got %0h want 0ab", rsp_data); end
        checks++; if (rsp_status !== ST_OK) begin errors++; $display("FAIL write_status: got %0b want 00", rsp_status); end
        checks++; if (wr_pulses !== 1) begin errors++; $display("FAIL write_bwr_pulse: got %0d cycles want 1", wr_pulses); end
        checks++; if (wr_count !== CNT'(exp_cnt)) begin errors++; $display("FAIL write_count: got %0d want %0d", wr_count, exp_cnt); end
        finish_rsp();
        wr_pulses = 0;
        send_cmd(OP_READ, 5'd0, 10'd5, 72'h0);
        wait_rsp(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency: got %0d want 3", lat); end
        checks++; if (rsp_data !== 72'h123) begin errors++; $display("FAIL read_data: got %0h want 123", rsp_data); end
        checks++; if (wr_pulses !== 0) begin errors++; $display("FAIL read_no_bwr: got %0d pulses want 0", wr_pulses); end
        finish_rsp();
    endtask

    task automatic test_wrong_stage();
        int lat;
        wr_pulses = 0;
        send_cmd(OP_WRITE, 5'd3, 10'd7, 72'h999);
        wait_rsp(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL wrong_stage_latency: got %0d want 1", lat); end
        checks++; if (rsp_status !== ST_WRONG_STAGE || rsp_data !== 72'h0) begin errors++; $display("FAIL wrong_stage_rsp: status %0b data %0h want 10/0", rsp_status, rsp_data); end
        finish_rsp();
        checks++; if (wr_pulses !== 0 || mem[7] !== 72'h0) begin errors++; $display("FAIL wrong_stage_no_access: pulses %0d mem %0h want 0/0", wr_pulses, mem[7]); end
        checks++; if (wr_count !== CNT'(exp_cnt)) begin errors++; $display("FAIL wrong_stage_count: got %0d want %0d", wr_count, exp_cnt); end
    endtask

    task automatic test_backpressure();
        int   lat;
        logic stable;
        send_cmd(OP_READ, 5'd0, 10'd5, 72'h0);
        wait_rsp(lat);
        // Queue a wrong-stage command during the stall; it must wait for the handshake
        cmd_op = OP_READ; cmd_stage = 5'd1; cmd_addr = 10'd3; cmd_data = '0;
        cmd_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== 72'h123 || rsp_status !== ST_OK || cmd_ready !== 1'b0)
                stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL stall_stable: last valid %0b data %0h ready %0b want 1/123/0", rsp_valid, rsp_data, cmd_ready); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_release: ready %0b valid %0b want 1/0", cmd_ready, rsp_valid); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_status !== ST_WRONG_STAGE || cmd_ready !== 1'b0) begin errors++; $display("FAIL stall_next_accept: valid %0b status %0b ready %0b want 1/10/0", rsp_valid, rsp_status, cmd_ready); end
        finish_rsp();
    endtask

    task automatic test_verify();
        send_cmd(OP_WRITE, 5'd0, 10'd9, 72'h55);
        exp_cnt++;
        repeat (3) @(posedge clk);
        #1 corrupt = 72'h1;
        @(posedge clk);
        #1 corrupt = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_status !== CORRUPT_ST) begin errors++; $display("FAIL verify_status: valid %0b status %0b want 1/%0b", rsp_valid, rsp_status, CORRUPT_ST); end
        checks++; if (rsp_data !== 72'h11 || mem[9] !== 72'h55) begin errors++; $display("FAIL verify_data: rsp %0h mem %0h want 11/55", rsp_data, mem[9]); end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        int lat;
        rsp_ready = 1'b1;
        send_cmd(OP_WRITE, 5'd0, 10'd0, 72'hA0A0);
        wait_rsp(lat);
        exp_cnt++;
        checks++; if (lat !== WR_LAT || rsp_data !== 72'h1) begin errors++; $display("FAIL b2b_first: lat %0d data %0h want %0d/1", lat, rsp_data, WR_LAT); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_one_cycle_resp: valid %0b ready %0b want 0/1", rsp_valid, cmd_ready); end
        send_cmd(OP_WRITE, 5'd0, 10'd1023, 72'hB0B0);
        wait_rsp(lat);
        exp_cnt++;
        checks++; if (lat !== WR_LAT || rsp_data !== 72'h2) begin errors++; $display("FAIL b2b_second: lat %0d data %0h want %0d/2", lat, rsp_data, WR_LAT); end
        @(posedge clk); #1;
        checks++; if (mem[0] !== 72'hA0A0 || mem[1023] !== 72'hB0B0) begin errors++; $display("FAIL b2b_mem: %0h %0h want a0a0/b0b0", mem[0], mem[1023]); end
        checks++; if (wr_count !== CNT'(exp_cnt)) begin errors++; $display("FAIL b2b_count: got %0d want %0d", wr_count, exp_cnt); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int lat;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16 && exp_cnt != 14; i++) begin
            send_cmd(OP_WRITE, 5'd0, 10'(100 + i), 72'(i));
            wait_rsp(lat);
            exp_cnt++;
            @(posedge clk); #1;
        end
        checks++; if (wr_count !== 4'hE) begin errors++; $display("FAIL wrap_pre: got %0h want e", wr_count); end
        send_cmd(OP_WRITE, 5'd0, 10'd200, 72'hC1);
        wait_rsp(lat);
        @(posedge clk); #1;
        checks++; if (wr_count !== 4'hF) begin errors++; $display("FAIL wrap_max: got %0h want f", wr_count); end
        send_cmd(OP_WRITE, 5'd0, 10'd201, 72'hC2);
        wait_rsp(lat);
        @(posedge clk); #1;
        exp_cnt = 0;
        checks++; if (wr_count !== 4'h0) begin errors++; $display("FAIL wrap_zero: got %0h want 0", wr_count); end
        checks++; if (mem[200] !== 72'hC1 || mem[201] !== 72'hC2) begin errors++; $display("FAIL wrap_mem: %0h %0h want c1/c2", mem[200], mem[201]); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        send_cmd(OP_WRITE, 5'd0, 10'd20, 72'h77);
        checks++; if (b_wr !== 1'b1) begin errors++; $display("FAIL mid_issue_bwr: got %0b want 1", b_wr); end
        rst = 1'b1;
        #1;
        checks++; if (b_wr !== 1'b0 || b_addr !== 10'h0 || b_din !== 72'h0) begin errors++; $display("FAIL mid_rst_portb: wr %0b addr %0h din %0h want 0", b_wr, b_addr, b_din); end
        checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 72'h0 || wr_count !== '0) begin errors++; $display("FAIL mid_rst_outputs: ready %0b valid %0b data %0h cnt %0h want 0", cmd_ready, rsp_valid, rsp_data, wr_count); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %0b want 1", cmd_ready); end
        send_cmd(OP_READ, 5'd0, 10'd5, 72'h0);
        wait_rsp(lat);
        checks++; if (lat !== 3 || rsp_data !== 72'h123 || rsp_status !== ST_OK) begin errors++; $display("FAIL mid_read_after: lat %0d data %0h status %0b want 3/123/00", lat, rsp_data, rsp_status); end
        finish_rsp();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[0]    = 72'h1;
        mem[5]    = 72'h0AB;
        mem[9]    = 72'h11;
        mem[1023] = 72'h2;
        test_reset();
        test_write_read();
        test_wrong_stage();
        test_backpressure();
        test_verify();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
